id_ex_stage_buf: RTL and testbench

Parametrised ID->EX pipeline stage register for the 5-stage datapath, generalising the plain ID/EX latch.
- Adds valid/ready flow control, stall back-pressure, flush-to-bubble and an optional 2-entry skid buffer, so the decode stage never sees combinational ready from EX.
- Carries the WB/M/EX control groups, two operand values, the sign-extended immediate and the rs/rt/rd register numbers.

---
 rtl/id_ex_stage_buf.sv | 127 ++++++++++++
 tb/tb_id_ex_stage_buf.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_buf.sv
// ID->EX pipeline stage register with valid/ready handshake, flush-to-bubble
// and an optional 2-entry skid buffer (SKID=1) that registers in_ready.
// Control groups read zero whenever out_valid is low; data fields hold.
module id_ex_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 2,
  parameter int EX_W   = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB,
  input  logic [M_W-1:0]    M,
  input  logic [EX_W-1:0]   EX,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] S_EXTEND_out_b,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   EX_WB,
  output logic [M_W-1:0]    EX_M,
  output logic [EX_W-1:0]   EX_EX,
  output logic [DATA_W-1:0] EX_SRC_A,
  output logic [DATA_W-1:0] EX_SRC_B,
  output logic [DATA_W-1:0] EX_SE,
  output logic [REG_W-1:0]  EX_rs,
  output logic [REG_W-1:0]  EX_rt,
  output logic [REG_W-1:0]  EX_rd,
  output logic [1:0]        occupancy
);

  // Control fields sit in the MSBs of the packed payload so they can be
  // zeroed as one slice when the main entry becomes a bubble.
  localparam int CW = WB_W + M_W + EX_W;
  localparam int PW = CW + 3 * DATA_W + 3 * REG_W;

  logic [PW-1:0] w_in_pay;
  logic [PW-1:0] r_main_pay;
  logic [PW-1:0] r_skid_pay;
  logic          r_main_valid;
  logic          r_skid_valid;
  logic          r_in_ready;
  logic [1:0]    r_occ;

  logic w_accept;
  logic w_consume;
  logic w_main_valid_n;
  logic w_skid_valid_n;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_in_pay  = {WB, M, EX, readData1, readData2, S_EXTEND_out_b, rs, rt, rd};

  // Without a skid slot, ready must look through to EX combinationally.
  assign in_ready  = (SKID != 0) ? r_in_ready : (out_ready | ~r_main_valid);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_main_valid & out_ready;

  // Next-state decision for the two entries; flush outranks every transfer.
  always_comb begin
    w_main_valid_n   = r_main_valid;
    w_skid_valid_n   = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_main_valid_n = 1'b0;
      w_skid_valid_n = 1'b0;
    end else if (r_skid_valid && w_consume) begin
      // in_ready is low while the skid is full, so no accept can collide here
      w_load_main_skid = 1'b1;
      w_main_valid_n   = 1'b1;
      w_skid_valid_n   = 1'b0;
    end else if (w_accept && (!r_main_valid || w_consume)) begin
      w_load_main_in = 1'b1;
      w_main_valid_n = 1'b1;
    end else if (w_accept && (SKID != 0)) begin
      w_load_skid    = 1'b1;
      w_skid_valid_n = 1'b1;
    end else if (w_consume) begin
      w_main_valid_n = 1'b0;
    end else begin
      w_main_valid_n = r_main_valid;
    end
  end

  // State registers: entries, registered ready flag and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_pay   <= {PW{1'b0}};
      r_skid_pay   <= {PW{1'b0}};
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_occ        <= 2'd0;
    end else begin
      r_main_valid <= w_main_valid_n;
      r_skid_valid <= w_skid_valid_n;
      r_in_ready   <= ~w_skid_valid_n;
      r_occ        <= {1'b0, w_main_valid_n} + {1'b0, w_skid_valid_n};
      if (w_load_main_in) begin
        r_main_pay <= w_in_pay;
      end else if (w_load_main_skid) begin
        r_main_pay <= r_skid_pay;
      end else if (!w_main_valid_n) begin
        r_main_pay[PW-1 -: CW] <= {CW{1'b0}};
      end
      if (w_load_skid) begin
        r_skid_pay <= w_in_pay;
      end
    end
  end

  assign {EX_WB, EX_M, EX_EX, EX_SRC_A, EX_SRC_B, EX_SE, EX_rs, EX_rt, EX_rd} = r_main_pay;
  assign out_valid = r_main_valid;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Self-checking bench: one SKID=1 and one SKID=0 instance share stimulus and
// are compared against a queue-based model of an ordered 2-slot / 1-slot buffer.
module tb_id_ex_stage_buf;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [4:0]  ex;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] se;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst, flush, in_valid, out_ready;
  beat_t cur;

  logic        o1_ir, o1_valid, o0_ir, o0_valid;
  logic [1:0]  o1_occ, o0_occ;
  logic [1:0]  o1_wb, o1_m, o0_wb, o0_m;
  logic [4:0]  o1_ex, o0_ex, o1_rs, o1_rt, o1_rd, o0_rs, o0_rt, o0_rd;
  logic [31:0] o1_a, o1_b, o1_se, o0_a, o0_b, o0_se;

  logic [123:0] obs1, obs0, exp1, exp0;
  assign obs1 = {o1_valid, o1_occ, o1_ir, o1_wb, o1_m, o1_ex, o1_a, o1_b, o1_se, o1_rs, o1_rt, o1_rd};
  assign obs0 = {o0_valid, o0_occ, o0_ir, o0_wb, o0_m, o0_ex, o0_a, o0_b, o0_se, o0_rs, o0_rt, o0_rd};

  beat_t q1[$];
  beat_t q0[$];
  beat_t last1, last0;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage_buf #(.SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o1_ir),
    .WB(cur.wb), .M(cur.m), .EX(cur.ex), .readData1(cur.a), .readData2(cur.b),
    .S_EXTEND_out_b(cur.se), .rs(cur.rs), .rt(cur.rt), .rd(cur.rd),
    .out_valid(o1_valid), .out_ready(out_ready),
    .EX_WB(o1_wb), .EX_M(o1_m), .EX_EX(o1_ex), .EX_SRC_A(o1_a), .EX_SRC_B(o1_b),
    .EX_SE(o1_se), .EX_rs(o1_rs), .EX_rt(o1_rt), .EX_rd(o1_rd), .occupancy(o1_occ)
  );

  id_ex_stage_buf #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o0_ir),
    .WB(cur.wb), .M(cur.m), .EX(cur.ex), .readData1(cur.a), .readData2(cur.b),
    .S_EXTEND_out_b(cur.se), .rs(cur.rs), .rt(cur.rt), .rd(cur.rd),
    .out_valid(o0_valid), .out_ready(out_ready),
    .EX_WB(o0_wb), .EX_M(o0_m), .EX_EX(o0_ex), .EX_SRC_A(o0_a), .EX_SRC_B(o0_b),
    .EX_SE(o0_se), .EX_rs(o0_rs), .EX_rt(o0_rt), .EX_rd(o0_rd), .occupancy(o0_occ)
  );

  function automatic beat_t rand_beat();
    beat_t b;
    b.wb = 2'($urandom);  b.m  = 2'($urandom);  b.ex = 5'($urandom);
    b.a  = $urandom;      b.b  = $urandom;      b.se = $urandom;
    b.rs = 5'($urandom);  b.rt = 5'($urandom);  b.rd = 5'($urandom);
    return b;
  endfunction

  // Shown beat: head of queue, or a bubble with zero control and held data.
  function automatic beat_t shown(input beat_t q_head, input bit nonempty, input beat_t last);
    beat_t b;
    if (nonempty) begin
      b = q_head;
    end else begin
      b = last;
      b.wb = 2'd0; b.m = 2'd0; b.ex = 5'd0;
    end
    return b;
  endfunction

  // Advance one clock and update the model; no comparisons here.
  task automatic tick();
    bit a1, c1, a0, c0;
    beat_t h1, h0;
    a1 = in_valid && (q1.size() < 2);
    c1 = out_ready && (q1.size() > 0);
    a0 = in_valid && ((q0.size() == 0) || out_ready);
    c0 = out_ready && (q0.size() > 0);
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete();
      last1 = '0; last0 = '0;
    end else if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (c1) void'(q1.pop_front());
      if (a1) q1.push_back(cur);
      if (c0) void'(q0.pop_front());
      if (a0) q0.push_back(cur);
    end
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
    #1;
    h1 = (q1.size() > 0) ? q1[0] : last1;
    h0 = (q0.size() > 0) ? q0[0] : last0;
    exp1 = {q1.size() != 0, 2'(q1.size()), q1.size() < 2, shown(h1, q1.size() != 0, last1)};
    exp0 = {q0.size() != 0, 2'(q0.size()), out_ready | (q0.size() == 0), shown(h0, q0.size() != 0, last0)};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; cur = rand_beat();
    tick(); tick();
    checks++;
    if (obs1 !== {1'b1 ^ 1'b1, 2'd0, 1'b1, 120'd0}) begin
      fails++; $display("FAIL reset_skid1 got %h exp %h", obs1, {1'b0, 2'd0, 1'b1, 120'd0});
    end
    checks++;
    if (obs0 !== {1'b0, 2'd0, 1'b1, 120'd0}) begin
      fails++; $display("FAIL reset_skid0 got %h exp %h", obs0, {1'b0, 2'd0, 1'b1, 120'd0});
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    cur = '0; cur.wb = 2'b11; cur.a = 32'h0000_00AA; cur.rt = 5'd9;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({o1_valid, o1_wb, o1_a, o1_rt, o1_occ} !== {1'b1, 2'b11, 32'hAA, 5'd9, 2'd1}) begin
      fails++; $display("FAIL basic got v=%b wb=%b a=%h rt=%0d occ=%0d exp v=1 wb=11 a=aa rt=9 occ=1",
                        o1_valid, o1_wb, o1_a, o1_rt, o1_occ);
    end
    checks++;
    if (obs0 !== exp0) begin fails++; $display("FAIL basic_skid0 got %h exp %h", obs0, exp0); end
    tick();
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1;
    cur = rand_beat(); cur.a = 32'h1; tick();
    cur = rand_beat(); cur.a = 32'h2; tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({o1_a, o1_occ, o1_ir, o1_valid} !== {32'h1, 2'd2, 1'b0, 1'b1}) begin
      fails++; $display("FAIL skid_full got a=%h occ=%0d ir=%b v=%b exp a=1 occ=2 ir=0 v=1", o1_a, o1_occ, o1_ir, o1_valid);
    end
    checks++;
    if (obs1 !== exp1) begin fails++; $display("FAIL skid_hold got %h exp %h", obs1, exp1); end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({o1_a, o1_valid, o1_occ} !== {32'h2, 1'b1, 2'd1}) begin
      fails++; $display("FAIL skid_drain got a=%h v=%b occ=%0d exp a=2 v=1 occ=1", o1_a, o1_valid, o1_occ);
    end
    checks++;
    if (obs1 !== exp1) begin fails++; $display("FAIL skid_drain_model got %h exp %h", obs1, exp1); end
    tick();
    checks++;
    if ({o1_valid, o1_ir} !== {1'b0, 1'b1}) begin
      fails++; $display("FAIL skid_empty got v=%b ir=%b exp v=0 ir=1", o1_valid, o1_ir);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    cur = rand_beat(); tick();
    cur = rand_beat(); tick();
    flush = 1'b1; cur = rand_beat(); cur.a = 32'h3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({o1_valid, o1_wb, o1_m, o1_ex, o1_occ, o1_ir} !== {1'b0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1}) begin
      fails++; $display("FAIL flush got v=%b wb=%b m=%b ex=%b occ=%0d ir=%b exp all zero ir=1",
                        o1_valid, o1_wb, o1_m, o1_ex, o1_occ, o1_ir);
    end
    checks++;
    if (obs0 !== exp0) begin fails++; $display("FAIL flush_skid0 got %h exp %h", obs0, exp0); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o1_valid !== 1'b0 || o0_valid !== 1'b0) begin
        fails++; $display("FAIL flush_no_resurrect got v1=%b v0=%b exp 0", o1_valid, o0_valid);
      end
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cur = rand_beat(); cur.a = 32'(i);
      tick();
      checks++;
      if ({o1_a, o1_ir, o1_occ, o0_a} !== {32'(i), 1'b1, 2'd1, 32'(i)}) begin
        fails++; $display("FAIL stream_%0d got a1=%h ir=%b occ=%0d a0=%h exp a=%h ir=1 occ=1",
                          i, o1_a, o1_ir, o1_occ, o0_a, i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1;
    cur = rand_beat(); tick();
    cur = rand_beat(); tick();
    checks++;
    if (o1_occ !== 2'd2) begin fails++; $display("FAIL mid_fill got occ=%0d exp 2", o1_occ); end
    rst = 1'b1; cur = rand_beat();
    tick();
    checks++;
    if (obs1 !== {1'b0, 2'd0, 1'b1, 120'd0}) begin
      fails++; $display("FAIL mid_reset got %h exp %h", obs1, {1'b0, 2'd0, 1'b1, 120'd0});
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if ({o1_valid, o0_valid} !== 2'b00) begin
      fails++; $display("FAIL mid_reset_capture got v1=%b v0=%b exp 0", o1_valid, o0_valid);
    end
  endtask

  task automatic test_skid0_stall();
    beat_t held;
    out_ready = 1'b1; in_valid = 1'b1; cur = rand_beat(); held = cur;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (o0_ir !== 1'b0) begin fails++; $display("FAIL skid0_comb_ready got %b exp 0", o0_ir); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({o0_valid, o0_a, o0_wb} !== {1'b1, held.a, held.wb}) begin
        fails++; $display("FAIL skid0_hold got v=%b a=%h wb=%b exp v=1 a=%h wb=%b", o0_valid, o0_a, o0_wb, held.a, held.wb);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (o0_ir !== 1'b1) begin fails++; $display("FAIL skid0_release got %b exp 1", o0_ir); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      cur       = rand_beat();
      tick();
      checks++;
      if (obs1 !== exp1) begin fails++; $display("FAIL random_skid1 cyc %0d got %h exp %h", i, obs1, exp1); end
      checks++;
      if (obs0 !== exp0) begin fails++; $display("FAIL random_skid0 cyc %0d got %h exp %h", i, obs0, exp0); end
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    last1 = '0; last0 = '0;
    #2;
    test_reset();
    test_basic();
    test_skid();
    test_flush();
    test_stream();
    test_reset_midstream();
    test_skid0_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
